// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the cache fill controller.
//   state_e  : controller state (IDLE, FILL)
//   owner_e  : cache that owns the fill in progress (OWN_I, OWN_D)
//   cnt_width: width of a counter that must reach the block word count itself
package mem_fill_pkg;

  typedef enum logic {IDLE, FILL} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam int unsigned DATA_W = 16;
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
  localparam int unsigned WORD_BYTES = 2;

  // One extra bit so the counter can hold the terminal value (words) itself.
  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(8);

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for a block fill. Saturates at Terminal.
//   clk  : clock
//   clr  : synchronous clear (priority over inc)
//   inc  : increment enable, ignored once the terminal count is reached
//   cnt  : current count
//   done : cnt == Terminal
module fill_word_counter #(
  parameter int unsigned Width    = 4,
  parameter int unsigned Terminal = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt,
  output logic             done
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && !done) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign done = (cnt_q == Width'(Terminal));
  assign cnt  = cnt_q;

endmodule

// File: rtl/mem_fill_controller.sv
// Cache fill controller between the I/D caches and pipelined main memory.
// Arbitrates write-through stores, D-cache misses and I-cache misses (that priority), streams
// one block from memory into the missing cache and writes its tag, and stalls the pipeline
// while a fill is pending or running.
//   clk, rst               : clock, synchronous active-high reset
//   icache_miss/_addr      : I-cache miss request and byte address
//   dcache_miss/_addr      : D-cache miss request and byte address
//   store_req/addr/data    : write-through store, issued to memory in one IDLE cycle
//   mainmem_data_out/valid : memory read return
//   mainmem_addr/data_in/wr: memory request
//   fill_data, fill_addr   : word and byte address written into the owner's data array
//   *_wr_data_array/tag    : per-cache array write strobes
//   stall_n                : low stalls the pipeline
//   busy                   : fill in progress
module mem_fill_controller
  import mem_fill_pkg::*;
#(
  parameter int unsigned MEM_LATENCY     = 4,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] mainmem_data_out,
  input  logic              mainmem_data_valid,
  output logic [ADDR_W-1:0] mainmem_addr,
  output logic [DATA_W-1:0] mainmem_data_in,
  output logic              mainmem_wr,
  output logic [DATA_W-1:0] fill_data,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              icache_wr_data_array,
  output logic              icache_wr_tag_array,
  output logic              dcache_wr_data_array,
  output logic              dcache_wr_tag_array,
  output logic              stall_n,
  output logic              busy
);

  localparam int unsigned CntW = cnt_width(WORDS_PER_BLOCK);

  // Memory is fully pipelined: issue never waits on returns, so latency only shapes timing.
  if (MEM_LATENCY == 0) begin : g_bad_latency
    $error("mem_fill_controller: MEM_LATENCY must be at least 1");
  end

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic            cnt_clr, issue_inc, recv_inc;
  logic [CntW-1:0] issue_cnt, recv_cnt, issue_word;
  logic            issue_done, recv_done, recv_last;
  logic [ADDR_W-1:0] issue_off, recv_off;

  // Counters sit at zero whenever no fill is running, so a new fill always starts at word 0.
  assign cnt_clr = rst || (state_q == IDLE);

  fill_word_counter #(
    .Width   (CntW),
    .Terminal(WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (issue_inc),
    .cnt (issue_cnt),
    .done(issue_done)
  );

  fill_word_counter #(
    .Width   (CntW),
    .Terminal(WORDS_PER_BLOCK)
  ) u_recv_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .inc (recv_inc),
    .cnt (recv_cnt),
    .done(recv_done)
  );

  // After the last issue the address holds on the final word of the block.
  assign issue_word = issue_done ? CntW'(WORDS_PER_BLOCK - 1) : issue_cnt;
  assign issue_off  = ADDR_W'(issue_word) * ADDR_W'(WORD_BYTES);
  assign recv_off   = ADDR_W'(recv_cnt) * ADDR_W'(WORD_BYTES);
  assign recv_last  = (recv_cnt == CntW'(WORDS_PER_BLOCK - 1)) && !recv_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    owner_d              = owner_q;
    base_d               = base_q;
    mainmem_addr         = '0;
    mainmem_data_in      = '0;
    mainmem_wr           = 1'b0;
    fill_data            = '0;
    fill_addr            = '0;
    icache_wr_data_array = 1'b0;
    icache_wr_tag_array  = 1'b0;
    dcache_wr_data_array = 1'b0;
    dcache_wr_tag_array  = 1'b0;
    issue_inc            = 1'b0;
    recv_inc             = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Returns arriving in IDLE belong to an aborted fill and are dropped.
        if (store_req) begin
          mainmem_wr      = 1'b1;
          mainmem_addr    = store_addr;
          mainmem_data_in = store_data;
        end else if (dcache_miss) begin
          state_d = FILL;
          owner_d = OWN_D;
          base_d  = dcache_miss_addr & ADDR_W'(BLOCK_MASK);
        end else if (icache_miss) begin
          state_d = FILL;
          owner_d = OWN_I;
          base_d  = icache_miss_addr & ADDR_W'(BLOCK_MASK);
        end
      end
      FILL: begin
        mainmem_addr = base_q + issue_off;
        issue_inc    = !issue_done;
        if (mainmem_data_valid) begin
          recv_inc  = 1'b1;
          fill_data = mainmem_data_out;
          fill_addr = base_q + recv_off;
          if (owner_q == OWN_D) begin
            dcache_wr_data_array = 1'b1;
            dcache_wr_tag_array  = recv_last;
          end else begin
            icache_wr_data_array = 1'b1;
            icache_wr_tag_array  = recv_last;
          end
          if (recv_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == FILL);
  assign stall_n = !busy && !((state_q == IDLE) && (icache_miss || dcache_miss));

endmodule
